// File: rtl/fifo_pkg.sv
// Shared helpers for the asynchronous FIFO pointer blocks (write and read side).
// Gray/binary conversions operate on zero-extended values, so any width up to MAX_W works.
package fifo_pkg;

  localparam int DEFAULT_ADDRSIZE = 4;
  localparam int MAX_W = 32;

  function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g);
    logic [MAX_W-1:0] b;
    b = '0;
    b[MAX_W-1] = g[MAX_W-1];
    for (int i = MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/sync_r2w.sv
// Two-flop synchroniser bringing the read-domain Gray pointer into the write clock.
module sync_r2w
  import fifo_pkg::*;
#(
  parameter int ADDRSIZE = DEFAULT_ADDRSIZE
) (
  input  logic              wclk,
  input  logic              wrst_n,
  input  logic [ADDRSIZE:0] rptr,
  output logic [ADDRSIZE:0] wq2_rptr
);

  logic [ADDRSIZE:0] wq1_rptr;

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wq1_rptr <= '0;
      wq2_rptr <= '0;
    end else begin
      wq1_rptr <= rptr;
      wq2_rptr <= wq1_rptr;
    end
  end

endmodule

// File: rtl/wptr_full.sv
// Write-side pointer and flag controller of the asynchronous FIFO: Gray write pointer,
// memory write strobe, full / almost-full / occupancy and a sticky overflow flag.
module wptr_full
  import fifo_pkg::*;
#(
  parameter int ADDRSIZE    = DEFAULT_ADDRSIZE,
  parameter int ALMOST_FULL = 12
) (
  input  logic                wclk,
  input  logic                wrst_n,
  input  logic                winc,
  input  logic [ADDRSIZE:0]   rptr,
  input  logic                wovf_clr,
  output logic [ADDRSIZE-1:0] waddr,
  output logic                wclken,
  output logic [ADDRSIZE:0]   wptr,
  output logic                wfull,
  output logic                walmost_full,
  output logic [ADDRSIZE:0]   wlevel,
  output logic                woverflow
);

  localparam int PW = ADDRSIZE + 1;
  // Full when the next write pointer equals the read pointer with its two MSBs inverted.
  localparam logic [ADDRSIZE:0] FULL_MASK = (PW)'(3) << (ADDRSIZE - 1);
  localparam logic [ADDRSIZE:0] AF_LEVEL  = (PW)'(ALMOST_FULL);

  logic [ADDRSIZE:0] wbin;
  logic [ADDRSIZE:0] wq2_rptr;
  logic [ADDRSIZE:0] wbinnext;
  logic [ADDRSIZE:0] wgraynext;
  logic [ADDRSIZE:0] rbin_s;
  logic [ADDRSIZE:0] wlevel_next;
  logic              wfull_next;
  logic              walmost_full_next;
  logic              woverflow_next;
  logic [MAX_W-1:0]  rbin_wide;
  logic              unused_rbin_hi;

  sync_r2w #(
    .ADDRSIZE(ADDRSIZE)
  ) u_sync_r2w (
    .wclk    (wclk),
    .wrst_n  (wrst_n),
    .rptr    (rptr),
    .wq2_rptr(wq2_rptr)
  );

  assign waddr  = wbin[ADDRSIZE-1:0];
  assign wclken = winc & ~wfull;

  always_comb begin
    wbinnext          = wbin + {{ADDRSIZE{1'b0}}, wclken};
    wgraynext         = (wbinnext >> 1) ^ wbinnext;
    rbin_wide         = gray2bin(MAX_W'(wq2_rptr));
    rbin_s            = rbin_wide[ADDRSIZE:0];
    unused_rbin_hi    = |rbin_wide[MAX_W-1:PW];
    // A stale read pointer can only make this look fuller than it really is.
    wlevel_next       = wbinnext - rbin_s;
    wfull_next        = (wgraynext == (wq2_rptr ^ FULL_MASK));
    walmost_full_next = (wlevel_next >= AF_LEVEL);
    woverflow_next    = (winc & wfull) | (woverflow & ~wovf_clr);
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin         <= '0;
      wptr         <= '0;
      wfull        <= 1'b0;
      walmost_full <= 1'b0;
      wlevel       <= '0;
      woverflow    <= 1'b0;
    end else begin
      wbin         <= wbinnext;
      wptr         <= wgraynext;
      wfull        <= wfull_next;
      walmost_full <= walmost_full_next;
      wlevel       <= wlevel_next;
      woverflow    <= woverflow_next;
    end
  end

endmodule

// File: tb/tb_wptr_full.sv
// Directed bench for wptr_full with ADDRSIZE=4, ALMOST_FULL=12.
module tb_wptr_full;

  logic       wclk = 1'b0;
  logic       wrst_n;
  logic       winc;
  logic [4:0] rptr;
  logic       wovf_clr;
  logic [3:0] waddr;
  logic       wclken;
  logic [4:0] wptr;
  logic       wfull;
  logic       walmost_full;
  logic [4:0] wlevel;
  logic       woverflow;

  int total = 0;
  int bad   = 0;

  wptr_full #(
    .ADDRSIZE(4),
    .ALMOST_FULL(12)
  ) dut (
    .wclk        (wclk),
    .wrst_n      (wrst_n),
    .winc        (winc),
    .rptr        (rptr),
    .wovf_clr    (wovf_clr),
    .waddr       (waddr),
    .wclken      (wclken),
    .wptr        (wptr),
    .wfull       (wfull),
    .walmost_full(walmost_full),
    .wlevel      (wlevel),
    .woverflow   (woverflow)
  );

  always #5 wclk = ~wclk;

  function automatic logic [4:0] g5(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic cyc;
    @(posedge wclk);
    #1;
  endtask

  task automatic test_reset;
    wrst_n = 1'b0; winc = 1'b0; wovf_clr = 1'b0; rptr = 5'd0;
    #12;
    wrst_n = 1'b1;
    cyc;
    total++; if (wptr !== 5'd0) begin bad++; $display("FAIL reset_wptr got=%b exp=%b", wptr, 5'd0); end
    total++; if (wlevel !== 5'd0) begin bad++; $display("FAIL reset_wlevel got=%0d exp=0", wlevel); end
    total++; if ({wfull, walmost_full, woverflow} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b exp=000", {wfull, walmost_full, woverflow}); end
    winc = 1'b1;
    cyc; cyc; cyc;
    total++; if (waddr !== 4'd3) begin bad++; $display("FAIL pre_reset_waddr got=%0d exp=3", waddr); end
    #2;
    wrst_n = 1'b0;
    #1;
    total++; if (wptr !== 5'd0) begin bad++; $display("FAIL async_reset_wptr got=%b exp=%b", wptr, 5'd0); end
    total++; if (waddr !== 4'd0) begin bad++; $display("FAIL async_reset_waddr got=%0d exp=0", waddr); end
    total++; if (wlevel !== 5'd0) begin bad++; $display("FAIL async_reset_wlevel got=%0d exp=0", wlevel); end
    total++; if ({wfull, walmost_full, woverflow} !== 3'b000) begin bad++; $display("FAIL async_reset_flags got=%b exp=000", {wfull, walmost_full, woverflow}); end
    #2;
    wrst_n = 1'b1;
    #1;
    total++; if (waddr !== 4'd0) begin bad++; $display("FAIL release_waddr got=%0d exp=0", waddr); end
    winc = 1'b0;
    cyc;
    $display("reset: wptr=%b waddr=%0d", wptr, waddr);
  endtask

  task automatic test_fill;
    rptr = 5'd0;
    for (int i = 0; i < 16; i++) begin
      winc = 1'b1;
      #1;
      total++; if (waddr !== 4'(i)) begin bad++; $display("FAIL fill_waddr[%0d] got=%0d exp=%0d", i, waddr, i); end
      total++; if (wclken !== 1'b1) begin bad++; $display("FAIL fill_wclken[%0d] got=%b exp=1", i, wclken); end
      cyc;
      total++; if (wlevel !== 5'(i + 1)) begin bad++; $display("FAIL fill_wlevel[%0d] got=%0d exp=%0d", i, wlevel, i + 1); end
      total++; if (walmost_full !== (i + 1 >= 12)) begin bad++; $display("FAIL fill_almost[%0d] got=%b exp=%b", i, walmost_full, (i + 1 >= 12)); end
      total++; if (wfull !== (i + 1 == 16)) begin bad++; $display("FAIL fill_full[%0d] got=%b exp=%b", i, wfull, (i + 1 == 16)); end
      $display("fill: write %0d waddr=%0d wlevel=%0d af=%b full=%b", i, 4'(i), wlevel, walmost_full, wfull);
    end
    winc = 1'b0;
    total++; if (wptr !== 5'b11000) begin bad++; $display("FAIL fill_wptr got=%b exp=11000", wptr); end
  endtask

  task automatic test_overflow;
    winc = 1'b1;
    #1;
    total++; if (wclken !== 1'b0) begin bad++; $display("FAIL ovf_wclken got=%b exp=0", wclken); end
    cyc;
    total++; if (wptr !== 5'b11000) begin bad++; $display("FAIL ovf_wptr_held got=%b exp=11000", wptr); end
    total++; if (waddr !== 4'd0) begin bad++; $display("FAIL ovf_waddr_held got=%0d exp=0", waddr); end
    total++; if (woverflow !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b exp=1", woverflow); end
    wovf_clr = 1'b1;
    cyc;
    total++; if (woverflow !== 1'b1) begin bad++; $display("FAIL ovf_set_wins got=%b exp=1", woverflow); end
    winc = 1'b0;
    cyc;
    total++; if (woverflow !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b exp=0", woverflow); end
    wovf_clr = 1'b0;
    $display("overflow: wptr=%b woverflow=%b", wptr, woverflow);
  endtask

  task automatic test_drain;
    rptr = 5'b00001;
    cyc;
    total++; if (wfull !== 1'b1) begin bad++; $display("FAIL drain_edge1_full got=%b exp=1", wfull); end
    cyc;
    total++; if (wfull !== 1'b1) begin bad++; $display("FAIL drain_edge2_full got=%b exp=1", wfull); end
    total++; if (wlevel !== 5'd16) begin bad++; $display("FAIL drain_edge2_level got=%0d exp=16", wlevel); end
    cyc;
    total++; if (wfull !== 1'b0) begin bad++; $display("FAIL drain_edge3_full got=%b exp=0", wfull); end
    total++; if (wlevel !== 5'd15) begin bad++; $display("FAIL drain_edge3_level got=%0d exp=15", wlevel); end
    total++; if (walmost_full !== 1'b1) begin bad++; $display("FAIL drain_almost got=%b exp=1", walmost_full); end
    $display("drain: wfull=%b wlevel=%0d", wfull, wlevel);
  endtask

  task automatic test_simultaneous;
    rptr = 5'b00011;
    cyc;
    cyc;
    winc = 1'b1;
    #1;
    total++; if (wclken !== 1'b1) begin bad++; $display("FAIL simul_wclken got=%b exp=1", wclken); end
    cyc;
    winc = 1'b0;
    total++; if (wlevel !== 5'd15) begin bad++; $display("FAIL simul_level got=%0d exp=15", wlevel); end
    total++; if (wfull !== 1'b0) begin bad++; $display("FAIL simul_full got=%b exp=0", wfull); end
    total++; if (wptr !== 5'b11001) begin bad++; $display("FAIL simul_wptr got=%b exp=11001", wptr); end
    $display("simultaneous: wlevel=%0d wfull=%b wptr=%b", wlevel, wfull, wptr);
  endtask

  task automatic test_wrap;
    logic [4:0] prev;
    int         cnt;
    int         exp_lvl;
    wrst_n = 1'b0; rptr = 5'd0; winc = 1'b0;
    #2;
    wrst_n = 1'b1;
    #1;
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      rptr = (cnt >= 2) ? g5(5'(cnt - 2)) : 5'd0;
      winc = 1'b1;
      prev = wptr;
      cyc;
      cnt++;
      exp_lvl = (cnt < 5) ? cnt : 5;
      total++; if (wptr !== g5(5'(cnt))) begin bad++; $display("FAIL wrap_wptr[%0d] got=%b exp=%b", k, wptr, g5(5'(cnt))); end
      total++; if ($countones(wptr ^ prev) != 1) begin bad++; $display("FAIL wrap_onebit[%0d] got=%b prev=%b exp one bit changed", k, wptr, prev); end
      total++; if (wfull !== 1'b0) begin bad++; $display("FAIL wrap_full[%0d] got=%b exp=0", k, wfull); end
      total++; if (wlevel !== 5'(exp_lvl)) begin bad++; $display("FAIL wrap_level[%0d] got=%0d exp=%0d", k, wlevel, exp_lvl); end
      $display("wrap: write %0d wptr=%b wlevel=%0d", k, wptr, wlevel);
    end
    winc = 1'b0;
  endtask

  initial begin
    test_reset;
    test_fill;
    test_overflow;
    test_drain;
    test_simultaneous;
    test_wrap;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
